fir_run_ctrl: RTL



---
 rtl/fir_ctrl_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/fir_run_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR run controller.
//   - state_t      : sequencer states
//   - BCD_DIGITS, MAX_DISPLAY, Y_WIDTH, SAMPLE_WIDTH : datapath sizing
//   - dd_step()    : one shift-add-3 step of the double-dabble conversion
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CONVERT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int BCD_DIGITS   = 4;
  localparam int Y_WIDTH      = 16;
  localparam int SAMPLE_WIDTH = 8;
  localparam int BCD_WIDTH    = 4 * BCD_DIGITS;
  localparam int DD_WIDTH     = BCD_WIDTH + Y_WIDTH;

  localparam logic [Y_WIDTH-1:0] MAX_DISPLAY = 16'd9999;

  // The shift register is {bcd, binary}. Every BCD nibble that is 5 or more
  // gets 3 added before the whole register shifts left by one. After
  // Y_WIDTH steps the upper BCD_WIDTH bits hold the decimal digits.
  function automatic logic [DD_WIDTH-1:0] dd_step(input logic [DD_WIDTH-1:0] s);
    logic [DD_WIDTH-1:0] t;
    t = s;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[Y_WIDTH + 4*d +: 4] >= 4'd5) begin
        t[Y_WIDTH + 4*d +: 4] = t[Y_WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    return {t[DD_WIDTH-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary to BCD converter (double-dabble, one bit per cycle).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load value and begin a conversion (single cycle)
//   value      : binary value to convert, must be <= 9999
//   ones..thousands : BCD result, valid while ready is high
//   ready      : one-cycle pulse during the last conversion cycle
// Conversion takes exactly Y_WIDTH cycles after the start cycle, independent
// of the value. The digits are presented combinationally from the final step
// so the caller can register them on the same edge that ends the conversion.
module bin2bcd_seq
  import fir_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Y_WIDTH-1:0] value,
  output logic [3:0]         ones,
  output logic [3:0]         tens,
  output logic [3:0]         hundreds,
  output logic [3:0]         thousands,
  output logic               ready
);

  localparam logic [3:0] LAST_STEP = 4'(Y_WIDTH - 1);

  logic [DD_WIDTH-1:0] shreg;
  logic [DD_WIDTH-1:0] shreg_next;
  logic [3:0]          step_cnt;
  logic                active;

  assign shreg_next = dd_step(shreg);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      step_cnt <= '0;
      active   <= 1'b0;
    end else if (start) begin
      shreg    <= {{BCD_WIDTH{1'b0}}, value};
      step_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      shreg    <= shreg_next;
      step_cnt <= step_cnt + 4'd1;
      if (step_cnt == LAST_STEP) begin
        active <= 1'b0;
      end
    end
  end

  assign ready     = active && (step_cnt == LAST_STEP);
  assign ones      = shreg_next[Y_WIDTH      +: 4];
  assign tens      = shreg_next[Y_WIDTH + 4  +: 4];
  assign hundreds  = shreg_next[Y_WIDTH + 8  +: 4];
  assign thousands = shreg_next[Y_WIDTH + 12 +: 4];

endmodule

// File: rtl/fir_run_ctrl.sv
// Sequencer for the FIR display path.
// Debounces the go button, latches the sample, pulses the FIR start, waits
// the filter latency, captures and saturates the result, converts it to BCD
// and presents registered digits to the 7-segment scan driver.
// Optional build macro: FIR_RUN_CTRL_AUTORUN_EN adds a free-running sample
// timer that issues a start every SAMPLE_PERIOD cycles.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   go_btn      : raw asynchronous push-button
//   in          : 8-bit sample switches
//   fir_y       : FIR result
//   fir_in      : registered sample to the FIR
//   fir_go      : one-cycle FIR start
//   ones..thousands : registered BCD digits
//   busy        : sequence in progress (ISSUE through DONE)
//   done        : one-cycle pulse when the digits update
//   ovf         : last result exceeded 9999 and was shown as 9999
// Handshake: there is no backpressure. fir_go is a single-cycle strobe, and
// fir_y is assumed valid FIR_LATENCY cycles after it and held until sampled.
module fir_run_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int FIR_LATENCY     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SAMPLE_PERIOD   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go_btn,
  input  logic [SAMPLE_WIDTH-1:0] in,
  input  logic [Y_WIDTH-1:0]      fir_y,
  output logic [SAMPLE_WIDTH-1:0] fir_in,
  output logic                    fir_go,
  output logic [3:0]              ones,
  output logic [3:0]              tens,
  output logic [3:0]              hundreds,
  output logic [3:0]              thousands,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LAT_W = (FIR_LATENCY > 1) ? $clog2(FIR_LATENCY) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FIR_LATENCY - 1);

  state_t state;
  state_t state_next;

  // Button synchronizer and debounce
  logic            sync1;
  logic            sync2;
  logic            btn_level;
  logic [DB_W-1:0] db_cnt;
  logic            btn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      btn_rise  <= 1'b0;
    end else begin
      sync1    <= go_btn;
      sync2    <= sync1;
      btn_rise <= 1'b0;
      // db_cnt counts consecutive synced samples that disagree with the
      // accepted level; the DEBOUNCE_CYCLES-th such sample flips the level.
      if (sync2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= sync2;
        db_cnt    <= '0;
        btn_rise  <= sync2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Autorun sample timer
  logic auto_tick;

`ifdef FIR_RUN_CTRL_AUTORUN_EN
  localparam int AR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [AR_W-1:0] AR_LAST = AR_W'(SAMPLE_PERIOD - 1);

  logic [AR_W-1:0] ar_cnt;

  // Free-running; ticks landing outside IDLE are simply not acted upon.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_cnt <= '0;
    end else if (ar_cnt == AR_LAST) begin
      ar_cnt <= '0;
    end else begin
      ar_cnt <= ar_cnt + AR_W'(1);
    end
  end

  assign auto_tick = (ar_cnt == AR_LAST);
`else
  // No timer in this build; a legal period (>= 1) never produces a tick.
  assign auto_tick = (SAMPLE_PERIOD < 1);
`endif

  logic start_evt;
  assign start_evt = btn_rise | auto_tick;

  // Converter
  logic               conv_start;
  logic [Y_WIDTH-1:0] conv_value;
  logic               conv_ready;
  logic [3:0]         conv_ones;
  logic [3:0]         conv_tens;
  logic [3:0]         conv_hundreds;
  logic [3:0]         conv_thousands;
  logic               y_over;

  assign y_over     = (fir_y > MAX_DISPLAY);
  assign conv_value = y_over ? MAX_DISPLAY : fir_y;

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .value     (conv_value),
    .ones      (conv_ones),
    .tens      (conv_tens),
    .hundreds  (conv_hundreds),
    .thousands (conv_thousands),
    .ready     (conv_ready)
  );

  // FSM
  logic [LAT_W-1:0] wait_cnt;
  logic             ovf_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_evt) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // The converter's load is the capture register for fir_y.
        conv_start = 1'b1;
        state_next = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_ready) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fir_in    <= '0;
      wait_cnt  <= '0;
      ovf_next  <= 1'b0;
      ones      <= '0;
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
      ovf       <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start_evt) begin
        fir_in <= in;
      end

      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + LAT_W'(1);
      end

      if (state == ST_CAPTURE) begin
        ovf_next <= y_over;
      end

      // Loaded on the edge into DONE so the new digits appear with done.
      if ((state == ST_CONVERT) && conv_ready) begin
        ones      <= conv_ones;
        tens      <= conv_tens;
        hundreds  <= conv_hundreds;
        thousands <= conv_thousands;
        ovf       <= ovf_next;
      end
    end
  end

  assign fir_go = (state == ST_ISSUE);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

endmodule
